// File: rtl/audio_display_pkg.sv
// Shared constants and helpers for the audio-to-display path (mic level meter and display checkers).
package audio_display_pkg;

  localparam int MIC_MIDPOINT = 2048;
  localparam int BAR_LEVELS   = 16;

  // Thermometer encoding of a bar count: n bars lights the n low bits.
  // Counts above the bar range saturate to all bars lit.
  function automatic logic [15:0] level_to_therm(input logic [4:0] lvl);
    logic [4:0] gap;
    if (lvl >= 5'(BAR_LEVELS)) begin
      return 16'hFFFF;
    end
    gap = 5'(BAR_LEVELS) - lvl;
    return 16'hFFFF >> gap;
  endfunction

endpackage

// File: rtl/volume_level_meter.sv
// Windowed peak-amplitude meter with fast-attack / slow-decay smoothing,
// producing a bar count and its thermometer code for the soundbar renderer.
module volume_level_meter
  import audio_display_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int MIDPOINT = MIC_MIDPOINT,
  parameter int WINDOW   = 4000,
  parameter int SHIFT    = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                freeze,
  output logic [4:0]          level,
  output logic [15:0]         bar_therm,
  output logic                level_valid
);

  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [SAMPLE_W-1:0] MID      = MIDPOINT[SAMPLE_W-1:0];
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [SAMPLE_W-1:0] MAX_BARS = SAMPLE_W'(BAR_LEVELS);

  logic [CNT_W-1:0]    count;
  logic [SAMPLE_W-1:0] peak;
  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] peak_next;
  logic [SAMPLE_W-1:0] peak_scaled;
  logic [4:0]          raw;
  logic [4:0]          level_new;
  logic                window_end;

  // Distance from the midpoint, running peak including this sample, and the smoothed level it implies.
  always_comb begin
    amp         = (sample >= MID) ? (sample - MID) : (MID - sample);
    peak_next   = (amp > peak) ? amp : peak;
    peak_scaled = peak_next >> SHIFT;
    raw         = (peak_scaled > MAX_BARS) ? 5'(BAR_LEVELS) : 5'(peak_scaled);
    level_new   = (raw >= level) ? raw : (level - 5'd1);
    window_end  = sample_valid && (count == LAST_CNT);
  end

  // Window counter, peak tracker and the displayed level register stage; level_valid marks each update.
  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      peak        <= '0;
      level       <= 5'd0;
      bar_therm   <= 16'h0000;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (window_end) begin
        count <= '0;
        peak  <= '0;
        if (!freeze) begin
          level       <= level_new;
          bar_therm   <= level_to_therm(level_new);
          level_valid <= 1'b1;
        end
      end else if (sample_valid) begin
        count <= count + CNT_W'(1);
        peak  <= peak_next;
      end
    end
  end

endmodule
